// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions for the move-entry stage and the winner checker.
package ttt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_COMMIT,
        S_SETTLE,
        S_RELEASE
    } state_t;

    localparam logic PLAYER1     = 1'b0;
    localparam logic PLAYER2     = 1'b1;
    localparam int   NUM_SQUARES = 9;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    // Cell 0..2 along one axis from precomputed bounds b0 <= b1 <= b2 <= b3; 3 means off-board.
    function automatic logic [1:0] axis_cell(input logic [12:0] pos,
                                             input logic [12:0] b0,
                                             input logic [12:0] b1,
                                             input logic [12:0] b2,
                                             input logic [12:0] b3);
        if (pos < b0 || pos >= b3) return 2'd3;
        if (pos < b1)              return 2'd0;
        if (pos < b2)              return 2'd1;
        return 2'd2;
    endfunction

endpackage

// File: rtl/square_decode.sv
// Combinational mapping of a cursor position to a board square index (row*3+col) and valid flag.
module square_decode
    import ttt_pkg::*;
#(
    parameter int BOARD_X0  = 212,
    parameter int BOARD_Y0  = 84,
    parameter int CELL_SIZE = 200
) (
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [3:0]  idx,
    output logic        valid
);

    // 13-bit bounds so the far edge of the board cannot wrap.
    localparam logic [12:0] X_B0 = 13'(BOARD_X0);
    localparam logic [12:0] X_B1 = 13'(BOARD_X0 + CELL_SIZE);
    localparam logic [12:0] X_B2 = 13'(BOARD_X0 + 2 * CELL_SIZE);
    localparam logic [12:0] X_B3 = 13'(BOARD_X0 + 3 * CELL_SIZE);
    localparam logic [12:0] Y_B0 = 13'(BOARD_Y0);
    localparam logic [12:0] Y_B1 = 13'(BOARD_Y0 + CELL_SIZE);
    localparam logic [12:0] Y_B2 = 13'(BOARD_Y0 + 2 * CELL_SIZE);
    localparam logic [12:0] Y_B3 = 13'(BOARD_Y0 + 3 * CELL_SIZE);

    logic [1:0] col;
    logic [1:0] row;

    // NOTE: every output is assigned on every pass through this block, so no latch can be inferred.
    always_comb begin
        col   = axis_cell({1'b0, xpos}, X_B0, X_B1, X_B2, X_B3);
        row   = axis_cell({1'b0, ypos}, Y_B0, Y_B1, Y_B2, Y_B3);
        valid = (col != 2'd3) && (row != 2'd3);
        idx   = valid ? (4'(row) * 4'd3 + 4'(col)) : 4'd0;
    end

endmodule

// File: rtl/board_ctrl.sv
// Move-entry stage: turns left-button presses into tic-tac-toe moves and publishes the board
// to the winner checker, freezing it while game_over is high.
module board_ctrl
    import ttt_pkg::*;
#(
    parameter int BOARD_X0  = 212,
    parameter int BOARD_Y0  = 84,
    parameter int CELL_SIZE = 200
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        new_game,
    input  logic        game_over,
    output logic [8:0]  square1to9,
    output logic [8:0]  square1to9_color,
    output logic        current_player,
    output logic [3:0]  move_count
);

    state_t      state;
    logic        btn_q;
    logic        settle_cnt;
    logic [11:0] x_cap;
    logic [11:0] y_cap;
    logic [3:0]  sq_idx;
    logic        sq_valid;
    logic [3:0]  dec_idx;
    logic        dec_valid;
    logic        press_edge;

    assign press_edge = mouse_left && !btn_q;

    square_decode #(
        .BOARD_X0  (BOARD_X0),
        .BOARD_Y0  (BOARD_Y0),
        .CELL_SIZE (CELL_SIZE)
    ) u_square_decode (
        .xpos  (x_cap),
        .ypos  (y_cap),
        .idx   (dec_idx),
        .valid (dec_valid)
    );

    // NOTE: non-blocking assignments so every register samples the values from before the edge.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state            <= S_IDLE;
            btn_q            <= 1'b0;
            settle_cnt       <= 1'b0;
            x_cap            <= '0;
            y_cap            <= '0;
            sq_idx           <= '0;
            sq_valid         <= 1'b0;
            square1to9       <= '0;
            square1to9_color <= '0;
            current_player   <= PLAYER1;
            move_count       <= '0;
        end else begin
            // The button register keeps tracking through new_game, so a held button yields no edge.
            btn_q <= mouse_left;
            if (new_game) begin
                state            <= S_IDLE;
                sq_valid         <= 1'b0;
                square1to9       <= '0;
                square1to9_color <= '0;
                current_player   <= PLAYER1;
                move_count       <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (press_edge && !game_over) begin
                            x_cap <= mouse_xpos;
                            y_cap <= mouse_ypos;
                            state <= S_DECODE;
                        end
                    end
                    S_DECODE: begin
                        sq_idx   <= dec_idx;
                        sq_valid <= dec_valid;
                        state    <= S_COMMIT;
                    end
                    S_COMMIT: begin
                        if (sq_valid && !square1to9[sq_idx]) begin
                            square1to9[sq_idx]       <= 1'b1;
                            square1to9_color[sq_idx] <= current_player;
                            current_player           <= ~current_player;
                            if (move_count != 4'(NUM_SQUARES))
                                move_count <= move_count + 4'd1;
                        end
                        settle_cnt <= 1'b0;
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        // Two cycles: lets the registered game_over catch up with the new board.
                        settle_cnt <= 1'b1;
                        if (settle_cnt)
                            state <= S_RELEASE;
                    end
                    S_RELEASE: begin
                        if (!mouse_left)
                            state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/board_ctrl.md
# board_ctrl

Move-entry stage for the tic-tac-toe board, directly upstream of the winner checker. Converts left-button presses at the mouse position into board moves. Rejects clicks on occupied squares or outside the board, and alternates players. Publishes the occupancy vector `square1to9` and owner vector `square1to9_color` that the winner checker consumes, and freezes the board once that checker asserts `game_over`.

## Interface
Parameters:
- `BOARD_X0`, default 212: x pixel of the board's left edge.
- `BOARD_Y0`, default 84: y pixel of the board's top edge.
- `CELL_SIZE`, default 200: side length of one square in pixels. The board spans 3×`CELL_SIZE` in each axis.

Ports:
- `pclk`  in  1  pixel clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `mouse_xpos`  in  12  cursor x, synchronous to `pclk`.
- `mouse_ypos`  in  12  cursor y, synchronous to `pclk`.
- `mouse_left`  in  1  left button level, synchronous to `pclk`.
- `new_game`  in  1  one-cycle pulse that clears the board.
- `game_over`  in  1  from the winner checker; registered there, so it lags the board by 1 cycle.
- `square1to9`  out  9  bit i = 1 when square i is occupied.
- `square1to9_color`  out  9  bit i = owner of square i (0 = player 1, 1 = player 2); 0 when empty.
- `current_player`  out  1  player to move next (0 = player 1).
- `move_count`  out  4  moves committed, 0..9.

## Operation
- Square index = row×3 + col. Bit 0 is the top-left square, bit 2 top-right, bit 8 bottom-right.
- Column decode:
  - col 0 if `BOARD_X0` ≤ x < `BOARD_X0`+`CELL_SIZE`
  - col 1 for the next `CELL_SIZE` pixels
  - col 2 for the next `CELL_SIZE` pixels
  - otherwise invalid.
- Row decode is the same rule applied to y from `BOARD_Y0`.
- Decode uses comparisons against parameter-derived constants only; no divider. Compare in 13 bits so the upper bound cannot overflow.
- Press detection: rising edge of `mouse_left`, taken from a registered copy of the button.
- FSM states:
  - IDLE: wait for a press edge. Go to DECODE if `game_over`=0; otherwise ignore the press.
  - DECODE: register the square index and a valid flag from the coordinates captured at the press edge. → COMMIT.
  - COMMIT: if valid and the square is free, set its occupancy bit, set its color bit to `current_player`, toggle `current_player`, and increment `move_count`. Otherwise make no change. → SETTLE.
  - SETTLE: hold 2 cycles so the winner checker's `game_over` reflects the new board. → RELEASE.
  - RELEASE: wait until `mouse_left`=0. → IDLE.
- When `game_over`=1, presses are ignored and the board holds. Only `new_game` or `rst` clears it.
- `new_game` clears all board state, sets `current_player`=0 and `move_count`=0, and forces the FSM to IDLE. It takes priority over any in-flight move, including one in COMMIT that same cycle. `rst` takes priority over `new_game`.
- A button held across `new_game` does not produce a move; a new rising edge is required.
- `move_count` saturates at 9. At 9 every square is occupied, so further presses are rejected by the occupancy check.

## Timing
- Reset values: `square1to9`=0, `square1to9_color`=0, `current_player`=0, `move_count`=0; FSM in IDLE; button register = 0.
- Latency: press edge seen at cycle N (button register updates). DECODE runs at N+1. Outputs update at the end of COMMIT, visible at N+3. Winner checker output is valid at N+4, within SETTLE.
- Earliest acceptance of the next press is at cycle N+5 plus the release time.
- `rst` asserted mid-move aborts the move with no partial write.
- Coordinates are sampled only in the cycle of the press edge; later cursor motion has no effect on that move.

## Structure
- Shared package `ttt_pkg`:
  - FSM state enum.
  - `PLAYER1`=1'b0 and `PLAYER2`=1'b1.
  - `NUM_SQUARES`=9.
  - Winner encoding shared with the checker (00 game on, 01 P1, 10 P2, 11 draw).
- One natural sub-module, `square_decode`: combinational mapping of (x, y) → 4-bit index plus valid flag, parameterised by the same three parameters.

## Test plan
All scenarios use the default parameters.
- Reset, then press at (312,184) → bit 0 set in `square1to9`, color bit 0 = 0, `current_player`=1, `move_count`=1, visible 3 cycles after the edge.
- Second press at (312,184) → rejected: board unchanged, `current_player` still 1, `move_count` still 1.
- Presses at (100,300) and at (812,300) (x = 3×`CELL_SIZE` boundary) → ignored.
- Press at (811,683) → bit 8 set, owned by the player to move.
- Alternating moves on squares 0, 3, 1, 4, 2 → winner checker reports 01 with `game_over`=1. A sixth press at square 8 is ignored; `move_count` stays 5.
- `new_game` pulse in the same cycle as COMMIT → all outputs zero the next cycle and no move is written. Holding `mouse_left` across the pulse produces no move until the button is released and pressed again.
